// File: rtl/logic32_serial_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : logic32_serial_unit_if
// Description : Request/complete bus for the bit-sliced 32-bit logic unit.
//               The master issues START with operands and operation code. The
//               slave returns the result register and the BUSY/DONE status.
// Revision    : 1.0 - initial release
// ============================================================================
interface logic32_serial_unit_if;
  logic        start;
  logic [1:0]  opr;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] y;
  logic        busy;
  logic        done;

  modport master (
    output start, opr, a, b,
    input  y, busy, done
  );

  modport slave (
    input  start, opr, a, b,
    output y, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/logic32_serial_unit.sv
`default_nettype none
// ============================================================================
// Module      : logic32_serial_unit
// Description : Multi-cycle 32-bit AND/OR/NOR/INV unit. Operands are latched on
//               an accepted START and processed SLICE_W bits per clock, LSB
//               slice first. DONE pulses for one cycle when the result is
//               complete.
// Revision    : 1.0 - initial release
// ============================================================================
module logic32_serial_unit #(
  parameter int SLICE_W = 8
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  logic32_serial_unit_if.slave bus
);

  localparam int c_N     = 32 / SLICE_W;
  localparam int c_CNT_W = (c_N > 1) ? $clog2(c_N) : 1;

  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_N - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
  // Mask covering one slice at bit 0. The 64-bit arithmetic keeps SLICE_W=32 exact.
  localparam logic [31:0] c_SLICE_ONES = 32'((64'd1 << SLICE_W) - 64'd1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t               r_state;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [31:0]          r_a;
  logic [31:0]          r_b;
  logic [1:0]           r_opr;
  logic [31:0]          r_y;
  logic                 r_busy;
  logic                 r_done;

  logic [31:0]          w_func;
  logic [31:0]          w_mask;
  int                   w_shift;

  // Full-width function of the latched operands. Only the slice selected by
  // r_cnt is merged into Y each cycle.
  always_comb begin
    w_func  = 32'h0000_0000;
    w_shift = int'(r_cnt) * SLICE_W;
    w_mask  = c_SLICE_ONES << w_shift;
    case (r_opr)
      2'b00:   w_func = r_a & r_b;
      2'b01:   w_func = r_a | r_b;
      2'b10:   w_func = ~(r_a | r_b);
      default: w_func = ~r_a;
    endcase
  end

  // Sequencer: accept in IDLE, one slice per RUN cycle, single FIN cycle for DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_a     <= 32'h0000_0000;
      r_b     <= 32'h0000_0000;
      r_opr   <= 2'b00;
      r_y     <= 32'h0000_0000;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_opr   <= bus.opr;
            r_y     <= 32'h0000_0000;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          // Y was cleared on acceptance, so OR-ing the masked slice in leaves
          // the not-yet-computed upper slices at zero.
          r_y <= r_y | (w_func & w_mask);
          if (r_cnt == c_CNT_LAST) begin
            r_done  <= 1'b1;
            r_state <= S_FIN;
          end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end
        S_FIN: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.y    = r_y;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_logic32_serial_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_logic32_serial_unit
// Description : Directed self-checking bench for logic32_serial_unit with
//               SLICE_W=8 (N=4 slices per operation).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_logic32_serial_unit;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  logic32_serial_unit_if bus ();

  logic32_serial_unit #(.SLICE_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an operation for exactly one edge (edge k), then drop START.
  task automatic issue(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv);
    bus.start = 1'b1;
    bus.opr   = o;
    bus.a     = av;
    bus.b     = bv;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.opr   = 2'b11;
    bus.a     = 32'hDEAD_BEEF;
    bus.b     = 32'hCAFE_F00D;
    rst_n     = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.y !== 32'h0) begin n_fail++; $display("FAIL reset_y: got %h want %h", bus.y, 32'h0); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
    n_cmp++; if (bus.y !== 32'h0) begin n_fail++; $display("FAIL idle_y: got %h want %h", bus.y, 32'h0); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL idle_done: got %b want 0", bus.done); end
  endtask

  task automatic test_and();
    issue(2'b00, 32'hF0F0_F0F0, 32'hFF00_FF00);
    n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL and_busy_k: got %b want 1", bus.busy); end
    repeat (3) tick();
    n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL and_done_early: got %b want 0", bus.done); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL and_busy_k3: got %b want 1", bus.busy); end
    tick();
    n_cmp++; if (bus.y !== 32'hF000_F000) begin n_fail++; $display("FAIL and_y: got %h want %h", bus.y, 32'hF000_F000); end
    n_cmp++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL and_done: got %b want 1", bus.done); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL and_busy_fin: got %b want 1", bus.busy); end
    tick();
    n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL and_done_after: got %b want 0", bus.done); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL and_busy_after: got %b want 0", bus.busy); end
    n_cmp++; if (bus.y !== 32'hF000_F000) begin n_fail++; $display("FAIL and_y_hold: got %h want %h", bus.y, 32'hF000_F000); end
  endtask

  task automatic test_slices();
    logic [31:0] exp_y [4];
    exp_y[0] = 32'h0000_0033;
    exp_y[1] = 32'h0000_3333;
    exp_y[2] = 32'h0033_3333;
    exp_y[3] = 32'h3333_3333;
    issue(2'b01, 32'h1111_1111, 32'h2222_2222);
    n_cmp++; if (bus.y !== 32'h0) begin n_fail++; $display("FAIL slice_clear: got %h want %h", bus.y, 32'h0); end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (bus.y !== exp_y[i]) begin n_fail++; $display("FAIL slice_%0d: got %h want %h", i, bus.y, exp_y[i]); end
    end
    tick();
  endtask

  task automatic test_nor_inv();
    issue(2'b10, 32'h0000_0000, 32'h0000_FFFF);
    repeat (4) tick();
    n_cmp++; if (bus.y !== 32'hFFFF_0000) begin n_fail++; $display("FAIL nor_y: got %h want %h", bus.y, 32'hFFFF_0000); end
    n_cmp++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL nor_done: got %b want 1", bus.done); end
    tick();
    issue(2'b11, 32'h1234_5678, 32'hFFFF_FFFF);
    repeat (4) tick();
    n_cmp++; if (bus.y !== 32'hEDCB_A987) begin n_fail++; $display("FAIL inv_y: got %h want %h", bus.y, 32'hEDCB_A987); end
    n_cmp++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL inv_done: got %b want 1", bus.done); end
    tick();
  endtask

  task automatic test_busy_ignore();
    int dcount;
    dcount = 0;
    issue(2'b00, 32'hFFFF_FFFF, 32'h0F0F_0F0F);
    tick();
    // START pulse sampled at edge k+2 with different operation and operands.
    bus.start = 1'b1;
    bus.opr   = 2'b01;
    bus.a     = 32'h0000_0000;
    bus.b     = 32'hFFFF_FFFF;
    tick();
    bus.start = 1'b0;
    for (int i = 3; i <= 8; i++) begin
      tick();
      if (bus.done === 1'b1) dcount++;
    end
    n_cmp++; if (bus.y !== 32'h0F0F_0F0F) begin n_fail++; $display("FAIL ignore_y: got %h want %h", bus.y, 32'h0F0F_0F0F); end
    n_cmp++; if (dcount !== 1) begin n_fail++; $display("FAIL ignore_done_count: got %0d want 1", dcount); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL ignore_busy: got %b want 0", bus.busy); end

    // START held high from edge j onward; operands change after acceptance.
    bus.start = 1'b1;
    bus.opr   = 2'b00;
    bus.a     = 32'hFFFF_0000;
    bus.b     = 32'hFFFF_FFFF;
    tick();
    bus.opr = 2'b01;
    bus.a   = 32'h0000_0001;
    bus.b   = 32'h0000_0010;
    repeat (4) tick();
    n_cmp++; if (bus.y !== 32'hFFFF_0000) begin n_fail++; $display("FAIL held_first_y: got %h want %h", bus.y, 32'hFFFF_0000); end
    n_cmp++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL held_first_done: got %b want 1", bus.done); end
    tick();
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL held_idle_busy: got %b want 0", bus.busy); end
    tick();
    bus.start = 1'b0;
    n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL held_accept_busy: got %b want 1", bus.busy); end
    n_cmp++; if (bus.y !== 32'h0) begin n_fail++; $display("FAIL held_accept_clear: got %h want %h", bus.y, 32'h0); end
    repeat (4) tick();
    n_cmp++; if (bus.y !== 32'h0000_0011) begin n_fail++; $display("FAIL held_second_y: got %h want %h", bus.y, 32'h0000_0011); end
    n_cmp++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL held_second_done: got %b want 1", bus.done); end
    tick();
  endtask

  task automatic test_reset_mid();
    int dcount;
    dcount = 0;
    issue(2'b01, 32'h1111_1111, 32'h2222_2222);
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.y !== 32'h0) begin n_fail++; $display("FAIL midrst_y: got %h want %h", bus.y, 32'h0); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.done !== 1'b0) dcount++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.done !== 1'b0) dcount++;
    end
    n_cmp++; if (dcount !== 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d pulses want 0", dcount); end
    issue(2'b00, 32'hFFFF_FFFF, 32'h8000_0001);
    repeat (3) tick();
    n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL post_done_early: got %b want 0", bus.done); end
    tick();
    n_cmp++; if (bus.y !== 32'h8000_0001) begin n_fail++; $display("FAIL post_y: got %h want %h", bus.y, 32'h8000_0001); end
    n_cmp++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL post_done: got %b want 1", bus.done); end
    tick();
    n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL post_done_after: got %b want 0", bus.done); end
  endtask

  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    rst_n     = 1'b1;
    bus.start = 1'b0;
    bus.opr   = 2'b00;
    bus.a     = 32'h0;
    bus.b     = 32'h0;
    test_reset();
    test_and();
    test_slices();
    test_nor_inv();
    test_busy_ignore();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/logic32_serial_unit.md
# logic32_serial_unit

Multi-cycle, bit-sliced 32-bit logic unit. It computes AND, OR, NOR or INV of two latched 32-bit operands one slice per clock, under a START/BUSY/DONE handshake. It is the sequential counterpart of the combinational 32-bit gate arrays. It serves datapath configurations that trade logic width for cycles, and gives the sequencer a clean request/complete interface.

## Interface
- SLICE_W, 8: bits processed per cycle; legal values 1, 2, 4, 8, 16, 32; N = 32/SLICE_W cycles per operation
- CLK  input  1  system clock, rising-edge active
- RST  input  1  reset; asynchronous, active-low
- START  input  1  operation request; sampled on rising CLK, honoured only in IDLE
- OPR  input  2  operation: 00 AND(A,B), 01 OR(A,B), 10 NOR(A,B), 11 INV(A) (B ignored)
- A  input  32  operand A; sampled with an accepted START
- B  input  32  operand B; sampled with an accepted START
- Y  output  32  result register
- BUSY  output  1  high whenever state != IDLE
- DONE  output  1  one-cycle completion pulse

## Operation
- States: IDLE, RUN, FIN.
- IDLE, START=1: on the clock edge, latch A, B and OPR internally, clear Y to 0, clear slice counter cnt to 0, go to RUN. If START=0, remain in IDLE.
- RUN: each edge writes Y[cnt*SLICE_W +: SLICE_W] = OPR-function of the latched slices. Then cnt increments. When cnt == N-1 on that edge, go to FIN instead of incrementing.
- Slices are processed LSB first. Not-yet-computed slices of Y read 0.
- FIN: DONE=1 for exactly this one cycle, then go to IDLE unconditionally.
- START in RUN or FIN is ignored: no relatch, no restart, no queueing. A START held high into IDLE is accepted on the first IDLE edge.
- A, B and OPR changes after acceptance have no effect on the operation in progress.
- Y holds the completed result from FIN onward, until the next accepted START clears it.
- cnt is wide enough for N-1 (clog2(N), minimum 1 bit). For SLICE_W=32, RUN lasts one cycle.
- RST low at any time forces asynchronously:
  - state = IDLE, cnt = 0
  - Y = 32'h0000_0000, BUSY = 0, DONE = 0
  - latched operands and OPR cleared to 0
  - an operation in progress is aborted, with no DONE pulse.
- Outputs are fully registered or decoded from state only. There is no combinational path from START, A, B or OPR to any output.

## Timing
- Reset values: Y = 0, BUSY = 0, DONE = 0.
- START accepted at edge k:
  - BUSY = 1 after edge k.
  - Slice i is written at edge k+1+i.
  - FIN is entered at edge k+N; DONE = 1 and BUSY = 1 for the cycle after edge k+N.
  - After edge k+N+1: IDLE, BUSY = 0, DONE = 0.
- Latency START to DONE: N+1 edges. Minimum issue interval: N+2 cycles. For SLICE_W=8: DONE follows START by 5 edges, and back-to-back operations are spaced 6 cycles apart.
- RST deassertion is synchronous to the first rising CLK edge that sees RST high. START on that edge is accepted.

## Test plan
- Reset: drive RST=0 mid-clock with junk on inputs -> immediately Y=0000_0000, BUSY=0, DONE=0. Release, idle 3 cycles -> outputs unchanged.
- AND, SLICE_W=8: A=F0F0_F0F0, B=FF00_FF00, OPR=00, START at edge k -> Y=F000_F000 and DONE=1 exactly after edge k+4. BUSY high from k+1 through k+4, low after k+5.
- Slice progression, OR: A=1111_1111, B=2222_2222 -> Y=0000_0033 after k+1, 0000_3333 after k+2, 0033_3333 after k+3, 3333_3333 after k+4.
- NOR and INV: A=0000_0000, B=0000_FFFF, OPR=10 -> FFFF_0000. A=1234_5678, B=FFFF_FFFF, OPR=11 -> EDCB_A987.
- Busy-ignore: START accepted with AND A=FFFF_FFFF, B=0F0F_0F0F. At k+2, pulse START with OR and new operands -> final Y=0F0F_0F0F, a single DONE pulse, no second operation. START held high through FIN -> new operation accepted at the first IDLE edge.
- Reset mid-operation: assert RST after edge k+2 of an OR -> Y=0, BUSY=0 immediately, no DONE. Release, then START AND A=FFFF_FFFF, B=8000_0001 -> Y=8000_0001 with correct N+1 latency.
